flag_gen: RTL and testbench
===========================

Name: flag_gen

Overview:
- Producer side of the flag register: computes Z/S/C/V from the ALU operands and result, and holds the architectural flag vector that the branch-condition decoder consumes.
- Keeps a 2-deep shadow stack so flags survive interrupt entry and return.
- Sits between the ALU output and the flag-register/branch decoder in the ONC-16 execute stage.

Parameters:
DATA_W, 16, ALU operand/result width
FLAG_W, 4, flag vector width; fixed at 4, other values unsupported
STK_D, 2, shadow stack depth; fixed at 2

Ports:
clock  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
a  input  DATA_W  ALU operand A
b  input  DATA_W  ALU operand B
res  input  DATA_W  ALU result
co  input  1  ALU adder carry-out (ADD) / raw carry-out of a+~b+1 (SUB)
so  input  1  bit shifted out (SHIFT)
op_cls  input  2  00 ADD, 01 SUB, 10 LOGIC, 11 SHIFT
fe  input  1  flag write enable
int_save  input  1  push current flags to shadow stack
int_rest  input  1  pop shadow stack into flags
flags  output  FLAG_W  registered flags: [0]=Z [1]=S [2]=C [3]=V
depth  output  2  shadow stack occupancy, 0..2
stk_err  output  1  sticky error: push while full or pop while empty

Behaviour:
- Reset (asynchronous, rst=1): flags=4'b0000, depth=0, both shadow entries=0, stk_err=0. Deassertion takes effect at the next rising edge; no glitching of flags.
- Flag computation is combinational from the inputs. Registration gives 1-cycle latency: inputs at edge N are visible on flags after edge N.
- Z = (res == 0).
- S = res[DATA_W-1].
- ADD:
  - C = co.
  - V = (a[msb] == b[msb]) && (res[msb] != a[msb]).
- SUB:
  - C = ~co, i.e. a borrow; C=1 iff a < b unsigned.
  - V = (a[msb] != b[msb]) && (res[msb] != a[msb]).
- LOGIC: C=0, V=0.
- SHIFT: C=so, V=0.
- fe=0 with no stack operation: flags hold.
- Push (int_save=1, int_rest=0):
  - If depth<2: entry[depth] <= flags (the pre-edge value), depth+1.
  - If fe=1 on the same cycle, flags still update to the new computed value. Save captures the old value and the register takes the new one.
  - Push when depth==2: no write, depth stays 2, stk_err <= 1.
- Pop (int_rest=1, int_save=0):
  - If depth>0: flags <= entry[depth-1], depth-1. Pop has priority over fe, so the computed flags are discarded.
  - Pop when depth==0: flags follow fe rules, depth stays 0, stk_err <= 1.
- int_save=1 and int_rest=1 together: treated as a swap.
  - If depth>0: flags <= entry[depth-1] and entry[depth-1] <= old flags; depth unchanged. fe ignored.
  - If depth==0: no stack change, stk_err <= 1, fe rules apply.
- stk_err is sticky and is cleared only by rst.
- Stack entries are registers, not RAM. Unused entries keep stale data; nothing reads them.

Test Plan:
- Reset mid-run: depth=1, flags=4'b1010, assert rst asynchronously between edges -> flags=0, depth=0, stk_err=0 immediately, before the next edge.
- ADD overflow: a=16'h7FFF, b=16'h0001, res=16'h8000, co=0, op=ADD, fe=1 -> next cycle flags=4'b1010 (V=1, C=0, S=1, Z=0).
- SUB equal/borrow:
  - a=b=16'h1234, res=0, co=1, op=SUB -> flags=4'b0001.
  - Then a=16'h0001, b=16'h0002, res=16'hFFFF, co=0 -> flags=4'b0110.
- LOGIC/SHIFT/hold:
  - LOGIC res=0 -> flags=4'b0001.
  - SHIFT res=16'h4000, so=1 -> flags=4'b0100.
  - fe=0 with changing inputs -> flags unchanged over 3 cycles.
- Nested interrupts:
  - flags=4'b0100, push -> depth=1.
  - Load 4'b1000, push -> depth=2.
  - Third push -> stk_err=1, depth=2.
  - Pop -> flags=4'b1000, depth=1.
  - Pop -> flags=4'b0100, depth=0.
  - Pop -> stk_err stays 1, depth=0.
- Simultaneous events:
  - Push with fe=1 (ADD res=0, co=1) -> entry gets the old flags, flags=4'b0101.
  - Next cycle pop with fe=1 -> restored old value; the computed value is discarded.
  - Swap at depth=1 exchanges flags and top entry; depth stays 1.

Source files
------------

// File: rtl/flag_gen.sv
// flag_gen: ONC-16 execute-stage flag producer.
// Computes Z/S/C/V from ALU operands/result, holds the architectural flag
// register, and keeps a 2-deep shadow stack for interrupt entry/return.
// flags bit order: [0]=Z [1]=S [2]=C [3]=V.
module flag_gen #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FLAG_W = 4,
    parameter int unsigned STK_D  = 2
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] res,
    input  logic              co,
    input  logic              so,
    input  logic [1:0]        op_cls,
    input  logic              fe,
    input  logic              int_save,
    input  logic              int_rest,
    output logic [FLAG_W-1:0] flags,
    output logic [1:0]        depth,
    output logic              stk_err
);

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOGIC = 2'b10,
        OP_SHIFT = 2'b11
    } op_e;

    op_e               op;
    logic              a_msb;
    logic              b_msb;
    logic              r_msb;
    logic              calc_z;
    logic              calc_s;
    logic              calc_c;
    logic              calc_v;
    logic [FLAG_W-1:0] calc_flags;

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic [1:0]        depth_q;
    logic [1:0]        depth_d;
    logic              err_q;
    logic              err_d;
    logic [FLAG_W-1:0] entry_q [STK_D];
    logic [FLAG_W-1:0] entry_d [STK_D];

    logic              has_top;
    logic              is_full;
    logic              top_idx;
    logic              push_idx;

    // Only the sign bits of the operands take part in overflow detection.
    logic              unused_operand_bits;
    assign unused_operand_bits = ^{a[DATA_W-2:0], b[DATA_W-2:0]};

    assign op    = op_e'(op_cls);
    assign a_msb = a[DATA_W-1];
    assign b_msb = b[DATA_W-1];
    assign r_msb = res[DATA_W-1];

    // Combinational flag computation for the current ALU operation.
    always_comb begin
        calc_z = (res == '0);
        calc_s = r_msb;
        calc_c = 1'b0;
        calc_v = 1'b0;
        unique case (op)
            OP_ADD: begin
                calc_c = co;
                calc_v = (a_msb == b_msb) && (r_msb != a_msb);
            end
            OP_SUB: begin
                // co is the raw carry of a+~b+1; the flag is a borrow.
                calc_c = ~co;
                calc_v = (a_msb != b_msb) && (r_msb != a_msb);
            end
            OP_LOGIC: begin
                calc_c = 1'b0;
                calc_v = 1'b0;
            end
            OP_SHIFT: begin
                calc_c = so;
                calc_v = 1'b0;
            end
            default: begin
                calc_c = 1'b0;
                calc_v = 1'b0;
            end
        endcase
        calc_flags = {calc_v, calc_c, calc_s, calc_z};
    end

    assign has_top  = (depth_q != 2'd0);
    assign is_full  = (depth_q == 2'd2);
    // depth 1 -> entry 0 on top, depth 2 -> entry 1 on top.
    assign top_idx  = depth_q[1];
    // Next free slot: depth 0 -> entry 0, depth 1 -> entry 1.
    assign push_idx = depth_q[0];

    // Next-state for flags, shadow stack and sticky error.
    always_comb begin
        flags_d = flags_q;
        depth_d = depth_q;
        err_d   = err_q;
        entry_d = entry_q;
        unique case ({int_save, int_rest})
            2'b11: begin
                // Swap: exchange live flags with the top entry; fe is ignored.
                if (has_top) begin
                    flags_d          = entry_q[top_idx];
                    entry_d[top_idx] = flags_q;
                end else begin
                    err_d = 1'b1;
                    if (fe) begin
                        flags_d = calc_flags;
                    end
                end
            end
            2'b01: begin
                // Pop wins over fe when the stack has an entry.
                if (has_top) begin
                    flags_d = entry_q[top_idx];
                    depth_d = depth_q - 2'd1;
                end else begin
                    err_d = 1'b1;
                    if (fe) begin
                        flags_d = calc_flags;
                    end
                end
            end
            2'b10: begin
                // Push saves the pre-edge flags; fe still loads new flags.
                if (!is_full) begin
                    entry_d[push_idx] = flags_q;
                    depth_d           = depth_q + 2'd1;
                end else begin
                    err_d = 1'b1;
                end
                if (fe) begin
                    flags_d = calc_flags;
                end
            end
            default: begin
                if (fe) begin
                    flags_d = calc_flags;
                end
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < STK_D; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < STK_D; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign flags   = flags_q;
    assign depth   = depth_q;
    assign stk_err = err_q;

endmodule

// File: tb/tb_flag_gen.sv
// tb_flag_gen: directed and randomized checks of flag_gen against a
// behavioural model (signed/unsigned arithmetic for flags, a queue for the
// shadow stack).
module tb_flag_gen;

    logic        clock = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        co;
    logic        so;
    logic [1:0]  op_cls;
    logic        fe;
    logic        int_save;
    logic        int_rest;
    logic [3:0]  flags;
    logic [1:0]  depth;
    logic        stk_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0] mf;
    logic       merr;
    logic [3:0] mq[$];

    flag_gen #(
        .DATA_W(16),
        .FLAG_W(4),
        .STK_D (2)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .res     (res),
        .co      (co),
        .so      (so),
        .op_cls  (op_cls),
        .fe      (fe),
        .int_save(int_save),
        .int_rest(int_rest),
        .flags   (flags),
        .depth   (depth),
        .stk_err (stk_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags from the architectural meaning of each operation.
    function automatic logic [3:0] ref_flags();
        int unsigned ua = a;
        int unsigned ub = b;
        int          sa = $signed(a);
        int          sb = $signed(b);
        int          r;
        logic        z = (res == 16'd0);
        logic        s = res[15];
        logic        c = 1'b0;
        logic        v = 1'b0;
        case (op_cls)
            2'd0: begin
                c = (ua + ub) > 65535;
                r = sa + sb;
                v = (r > 32767) || (r < -32768);
            end
            2'd1: begin
                c = ua < ub;
                r = sa - sb;
                v = (r > 32767) || (r < -32768);
            end
            2'd3: c = so;
            default: c = 1'b0;
        endcase
        return {v, c, s, z};
    endfunction

    task automatic model_reset();
        mf   = 4'd0;
        merr = 1'b0;
        mq.delete();
    endtask

    task automatic model_step();
        logic [3:0] calc = ref_flags();
        logic [3:0] tmp;
        if (int_save && int_rest) begin
            if (mq.size() > 0) begin
                tmp = mq[mq.size()-1];
                mq[mq.size()-1] = mf;
                mf = tmp;
            end else begin
                merr = 1'b1;
                if (fe) mf = calc;
            end
        end else if (int_rest) begin
            if (mq.size() > 0) begin
                mf = mq.pop_back();
            end else begin
                merr = 1'b1;
                if (fe) mf = calc;
            end
        end else if (int_save) begin
            if (mq.size() < 2) mq.push_back(mf);
            else merr = 1'b1;
            if (fe) mf = calc;
        end else if (fe) begin
            mf = calc;
        end
    endtask

    // Drive a consistent ALU operation plus control inputs.
    task automatic drive(input logic [1:0] op, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ife, input logic is, input logic ir);
        logic [16:0] w;
        op_cls   = op;
        a        = ia;
        b        = ib;
        fe       = ife;
        int_save = is;
        int_rest = ir;
        case (op)
            2'd0: begin
                w   = {1'b0, ia} + {1'b0, ib};
                res = w[15:0];
                co  = w[16];
                so  = 1'($urandom_range(0, 1));
            end
            2'd1: begin
                w   = {1'b0, ia} + {1'b0, ~ib} + 17'd1;
                res = w[15:0];
                co  = w[16];
                so  = 1'($urandom_range(0, 1));
            end
            2'd2: begin
                res = ia ^ ib;
                co  = 1'($urandom_range(0, 1));
                so  = 1'($urandom_range(0, 1));
            end
            default: begin
                res = ia << 1;
                so  = ia[15];
                co  = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        #1;
        model_step();
        check({tag, "_flags"}, {4'd0, flags}, {4'd0, mf});
        check({tag, "_depth"}, {6'd0, depth}, 8'(mq.size()));
        check({tag, "_err"}, {7'd0, stk_err}, {7'd0, merr});
    endtask

    initial begin
        rst = 1'b1;
        drive(2'd2, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        #12;
        model_reset();
        check("reset_flags", {4'd0, flags}, 8'h00);
        check("reset_depth", {6'd0, depth}, 8'h00);
        check("reset_err", {7'd0, stk_err}, 8'h00);
        rst = 1'b0;

        drive(2'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        tick("add_ovf");
        check("add_ovf_const", {4'd0, flags}, 8'h0A);

        drive(2'd1, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);
        tick("sub_eq");
        check("sub_eq_const", {4'd0, flags}, 8'h01);

        drive(2'd1, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0);
        tick("sub_borrow");
        check("sub_borrow_const", {4'd0, flags}, 8'h06);

        drive(2'd2, 16'h5A5A, 16'h5A5A, 1'b1, 1'b0, 1'b0);
        tick("logic_zero");
        check("logic_zero_const", {4'd0, flags}, 8'h01);

        drive(2'd3, 16'hA000, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick("shift");
        check("shift_const", {4'd0, flags}, 8'h04);

        for (int i = 0; i < 3; i++) begin
            drive(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
            tick("hold");
            check("hold_const", {4'd0, flags}, 8'h04);
        end

        // Nested interrupts
        drive(2'd2, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick("push1");
        check("push1_depth", {6'd0, depth}, 8'h01);
        drive(2'd1, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        tick("load_v");
        check("load_v_const", {4'd0, flags}, 8'h08);
        drive(2'd2, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
        tick("push2");
        check("push2_depth", {6'd0, depth}, 8'h02);
        tick("push_full");
        check("push_full_err", {7'd0, stk_err}, 8'h01);
        check("push_full_depth", {6'd0, depth}, 8'h02);
        drive(2'd2, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick("pop1");
        check("pop1_const", {4'd0, flags}, 8'h08);
        check("pop1_depth", {6'd0, depth}, 8'h01);
        tick("pop2");
        check("pop2_const", {4'd0, flags}, 8'h04);
        check("pop2_depth", {6'd0, depth}, 8'h00);
        tick("pop_empty");
        check("pop_empty_err", {7'd0, stk_err}, 8'h01);
        check("pop_empty_depth", {6'd0, depth}, 8'h00);

        // Simultaneous events
        drive(2'd0, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0);
        tick("push_fe");
        check("push_fe_const", {4'd0, flags}, 8'h05);
        drive(2'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b1);
        tick("pop_fe");
        check("pop_fe_const", {4'd0, flags}, 8'h04);
        drive(2'd2, 16'h0003, 16'h0003, 1'b1, 1'b1, 1'b0);
        tick("push_logic");
        check("push_logic_const", {4'd0, flags}, 8'h01);
        drive(2'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b1, 1'b1);
        tick("swap");
        check("swap_const", {4'd0, flags}, 8'h04);
        check("swap_depth", {6'd0, depth}, 8'h01);
        drive(2'd2, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick("pop_swapped");
        check("pop_swapped_const", {4'd0, flags}, 8'h01);

        // Asynchronous reset between edges
        drive(2'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b1, 1'b0);
        tick("pre_rst");
        check("pre_rst_const", {4'd0, flags}, 8'h0A);
        check("pre_rst_depth", {6'd0, depth}, 8'h01);
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_flags", {4'd0, flags}, 8'h00);
        check("async_rst_depth", {6'd0, depth}, 8'h00);
        check("async_rst_err", {7'd0, stk_err}, 8'h00);
        drive(2'd0, 16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        check("rst_held_flags", {4'd0, flags}, 8'h00);
        check("rst_held_depth", {6'd0, depth}, 8'h00);
        rst = 1'b0;

        // Swap with empty stack: error, fe applies
        drive(2'd3, 16'h4000, 16'h0000, 1'b1, 1'b1, 1'b1);
        tick("swap_empty");
        check("swap_empty_const", {4'd0, flags}, 8'h02);
        check("swap_empty_err", {7'd0, stk_err}, 8'h01);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            if ((i % 150) == 75) begin
                rst = 1'b1;
                #1;
                model_reset();
                check("rnd_rst_flags", {4'd0, flags}, 8'h00);
                check("rnd_rst_err", {7'd0, stk_err}, 8'h00);
                rst = 1'b0;
            end
            drive(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 5) == 0));
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
